vdc_pixelgen: RTL and testbench

Downstream of the VDC RAM interface. Consumes the per-row screen/attribute latches and the per-column character bitmap byte, and serialises them into a 4-bit RGBI pixel stream, one pixel per pixel-clock enable. It applies character width, attributes, cursor, underline, blink, reverse and semigraphics, and substitutes background colour outside the display window.

---
 rtl/vdc_pixelgen.sv | 241 ++++++++++++++++++++++++
 tb/tb_vdc_pixelgen.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_pixelgen.sv
// rtl/vdc_pixelgen.sv - VDC character/bitmap pixel serialiser producing a 4-bit RGBI stream
//
// Purpose:
//   Takes the per-column character bitmap byte and the per-row attribute
//   latches fetched upstream and turns them into one RGBI pixel per enable.
//   Handles character width clamping, double-width pixels, semigraphics
//   fill, underline, character blink, per-cell reverse, the text cursor and
//   the border/background substitution outside the display window.
//
// Ports:
//   clk, reset_n       system clock, synchronous active-low reset
//   enable             pixel clock enable; every state update is qualified by it
//   newFrame           frame start strobe (any nonzero bit)
//   newCol             first pixel of a character column
//   visible            bit1 = display line active
//   col, line          current column index, scanline within character row
//   reg_*              VDC register fields (geometry, modes, colours, cursor)
//   dispaddr           screen address of column 0 of the current row
//   rowbuf             selects which attribute row buffer is current
//   attrbuf            two attribute row buffers of A_LATCH_WIDTH bytes
//   charbuf            C_LATCH_WIDTH character bitmap bytes
//   rgbi               registered pixel colour

module vdc_pixelgen #(
    parameter int C_LATCH_WIDTH = 4,
    parameter int A_LATCH_WIDTH = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  newFrame,
    input  logic        newCol,
    input  logic [1:0]  visible,
    input  logic [7:0]  col,
    input  logic [4:0]  line,
    input  logic [7:0]  reg_hd,
    input  logic [3:0]  reg_cth,
    input  logic [3:0]  reg_cdh,
    input  logic        reg_text,
    input  logic        reg_atr,
    input  logic        reg_semi,
    input  logic        reg_dbl,
    input  logic        reg_rvs,
    input  logic        reg_crb,
    input  logic [3:0]  reg_fg,
    input  logic [3:0]  reg_bg,
    input  logic [4:0]  reg_ul,
    input  logic [1:0]  reg_cm,
    input  logic [4:0]  reg_cs,
    input  logic [4:0]  reg_ce,
    input  logic [15:0] reg_cp,
    input  logic [15:0] dispaddr,
    input  logic        rowbuf,
    input  logic [7:0]  attrbuf [2][A_LATCH_WIDTH],
    input  logic [7:0]  charbuf [C_LATCH_WIDTH],
    output logic [3:0]  rgbi
);

    localparam int CW = (C_LATCH_WIDTH > 1) ? $clog2(C_LATCH_WIDTH) : 1;
    localparam int AW = (A_LATCH_WIDTH > 1) ? $clog2(A_LATCH_WIDTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0] frame_q,  frame_d;
    logic [7:0] shift_q,  shift_d;
    logic [7:0] attr_q,   attr_d;
    logic       hit_q,    hit_d;
    logic       border_q, border_d;
    logic [3:0] px_q,     px_d;
    logic       phase_q,  phase_d;
    logic [3:0] rgbi_q,   rgbi_d;

    // visible[0] carries no meaning for pixel generation
    logic unused_visible;
    assign unused_visible = visible[0];

    // ------------------------------------------------------------------
    // Cell fetch: one column of latency, so the cell shown is col-1
    // ------------------------------------------------------------------
    logic [7:0] dcol;
    logic       cell_active;
    logic [7:0] char_rd;
    logic [7:0] attr_rd;
    logic       cursor_hit;

    assign dcol        = col - 8'd1;
    assign cell_active = visible[1] && (col != 8'd0) && (col <= reg_hd);
    assign char_rd     = charbuf[dcol[CW-1:0]];
    assign cursor_hit  = ((dispaddr + {8'd0, dcol}) == reg_cp);

    always_comb begin
        attr_rd = 8'd0;
        if ({24'd0, dcol} < 32'(A_LATCH_WIDTH)) begin
            attr_rd = attrbuf[rowbuf][dcol[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        frame_d  = frame_q;
        shift_d  = shift_q;
        attr_d   = attr_q;
        hit_d    = hit_q;
        border_d = border_q;
        px_d     = px_q;
        phase_d  = phase_q;

        if (enable) begin
            // Frame counter moves first so a coincident newCol sees the new value
            if (newFrame != 2'b00) begin
                frame_d = frame_q + 6'd1;
            end

            if (newCol) begin
                px_d    = 4'd0;
                phase_d = 1'b0;
                if (cell_active) begin
                    border_d = 1'b0;
                    shift_d  = char_rd;
                    attr_d   = reg_atr ? attr_rd : {4'b0000, reg_fg};
                    hit_d    = cursor_hit;
                end else begin
                    border_d = 1'b1;
                    hit_d    = 1'b0;
                end
            end else if (reg_dbl) begin
                // Each pixel is held for two enables
                phase_d = ~phase_q;
                if (phase_q && (px_q != 4'hF)) begin
                    px_d = px_q + 4'd1;
                end
            end else if (px_q != 4'hF) begin
                px_d = px_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel evaluation, computed from the state the pixel will use
    // ------------------------------------------------------------------
    logic [3:0] eff_cdh;
    logic [3:0] last_px;
    logic       raw_bit;
    logic       pix_bit;
    logic       blink_on;
    logic       cm_on;
    logic       cursor_on;
    logic [3:0] fg;
    logic [3:0] bg;

    // Displayed width never exceeds total width, and only 8 bitmap bits exist
    assign eff_cdh = (reg_cdh > reg_cth) ? reg_cth : reg_cdh;
    assign last_px = eff_cdh[3] ? 4'd7 : eff_cdh;

    assign blink_on = reg_crb ? frame_d[5] : frame_d[4];

    always_comb begin
        cm_on = 1'b0;
        case (reg_cm)
            2'b00:   cm_on = 1'b1;
            2'b01:   cm_on = 1'b0;
            2'b10:   cm_on = frame_d[3];
            default: cm_on = frame_d[4];
        endcase
    end

    assign cursor_on = hit_d && (line >= reg_cs) && (line < reg_ce) && cm_on;

    always_comb begin
        // Beyond the displayed width, semigraphics replicates the last bit
        if (px_d <= last_px) begin
            raw_bit = shift_d[3'd7 - px_d[2:0]];
        end else begin
            raw_bit = reg_semi & shift_d[0];
        end

        pix_bit = raw_bit;
        if (!reg_text) begin
            if (attr_d[5] && (line == reg_ul)) begin
                pix_bit = 1'b1;
            end
            if (attr_d[4] && !blink_on) begin
                pix_bit = 1'b0;
            end
            pix_bit = pix_bit ^ attr_d[6];
            pix_bit = pix_bit ^ cursor_on;
        end
    end

    always_comb begin
        if (!reg_text) begin
            fg = attr_d[3:0];
            bg = reg_bg;
        end else if (reg_atr) begin
            fg = attr_d[7:4];
            bg = attr_d[3:0];
        end else begin
            fg = reg_fg;
            bg = reg_bg;
        end
    end

    always_comb begin
        if (border_d) begin
            rgbi_d = reg_rvs ? reg_fg : reg_bg;
        end else begin
            rgbi_d = (pix_bit ^ reg_rvs) ? fg : bg;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q  <= 6'd0;
            shift_q  <= 8'd0;
            attr_q   <= 8'd0;
            hit_q    <= 1'b0;
            border_q <= 1'b0;
            px_q     <= 4'd0;
            phase_q  <= 1'b0;
            rgbi_q   <= 4'd0;
        end else if (enable) begin
            frame_q  <= frame_d;
            shift_q  <= shift_d;
            attr_q   <= attr_d;
            hit_q    <= hit_d;
            border_q <= border_d;
            px_q     <= px_d;
            phase_q  <= phase_d;
            rgbi_q   <= rgbi_d;
        end
    end

    assign rgbi = rgbi_q;

endmodule

// File: tb/tb_vdc_pixelgen.sv
// tb/tb_vdc_pixelgen.sv - directed self-checking bench for vdc_pixelgen

module tb_vdc_pixelgen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  newFrame;
    logic        newCol;
    logic [1:0]  visible;
    logic [7:0]  col;
    logic [4:0]  line;
    logic [7:0]  reg_hd;
    logic [3:0]  reg_cth;
    logic [3:0]  reg_cdh;
    logic        reg_text;
    logic        reg_atr;
    logic        reg_semi;
    logic        reg_dbl;
    logic        reg_rvs;
    logic        reg_crb;
    logic [3:0]  reg_fg;
    logic [3:0]  reg_bg;
    logic [4:0]  reg_ul;
    logic [1:0]  reg_cm;
    logic [4:0]  reg_cs;
    logic [4:0]  reg_ce;
    logic [15:0] reg_cp;
    logic [15:0] dispaddr;
    logic        rowbuf;
    logic [7:0]  attrbuf [2][80];
    logic [7:0]  charbuf [4];
    logic [3:0]  rgbi;

    int checks;
    int errors;

    vdc_pixelgen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .newFrame (newFrame),
        .newCol   (newCol),
        .visible  (visible),
        .col      (col),
        .line     (line),
        .reg_hd   (reg_hd),
        .reg_cth  (reg_cth),
        .reg_cdh  (reg_cdh),
        .reg_text (reg_text),
        .reg_atr  (reg_atr),
        .reg_semi (reg_semi),
        .reg_dbl  (reg_dbl),
        .reg_rvs  (reg_rvs),
        .reg_crb  (reg_crb),
        .reg_fg   (reg_fg),
        .reg_bg   (reg_bg),
        .reg_ul   (reg_ul),
        .reg_cm   (reg_cm),
        .reg_cs   (reg_cs),
        .reg_ce   (reg_ce),
        .reg_cp   (reg_cp),
        .dispaddr (dispaddr),
        .rowbuf   (rowbuf),
        .attrbuf  (attrbuf),
        .charbuf  (charbuf),
        .rgbi     (rgbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One enable cycle; outputs are sampled 1ns after the edge by the caller
    task automatic pulse(input logic nc, input logic [1:0] nf);
        enable   = 1'b1;
        newCol   = nc;
        newFrame = nf;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        newCol   = 1'b0;
        newFrame = 2'b00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_defaults();
        reset_n  = 1'b1;
        enable   = 1'b0;
        newFrame = 2'b00;
        newCol   = 1'b0;
        visible  = 2'b10;
        col      = 8'd1;
        line     = 5'd3;
        reg_hd   = 8'd80;
        reg_cth  = 4'd7;
        reg_cdh  = 4'd7;
        reg_text = 1'b0;
        reg_atr  = 1'b1;
        reg_semi = 1'b0;
        reg_dbl  = 1'b0;
        reg_rvs  = 1'b0;
        reg_crb  = 1'b0;
        reg_fg   = 4'hF;
        reg_bg   = 4'h0;
        reg_ul   = 5'd10;
        reg_cm   = 2'b01;
        reg_cs   = 5'd0;
        reg_ce   = 5'd0;
        reg_cp   = 16'hFFFF;
        dispaddr = 16'h0100;
        rowbuf   = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 80; i++)
                attrbuf[r][i] = 8'h00;
        for (int i = 0; i < 4; i++)
            charbuf[i] = 8'h00;
    endtask

    task automatic test_reset();
        set_defaults();
        charbuf[0]    = 8'hFF;
        attrbuf[0][0] = 8'h07;
        col = 8'd1;
        pulse(1'b1, 2'b00);
        pulse(1'b0, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL reset_precond rgbi=%h exp=%h", rgbi, 4'h7);
        end
        // Reset mid-line, with enable held high
        reset_n = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rgbi !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold%0d rgbi=%h exp=%h", i, rgbi, 4'h0);
            end
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        visible = 2'b00;
        reg_bg  = 4'h2;
        pulse(1'b0, 2'b00);
        checks++;
        if (rgbi !== 4'h2) begin
            errors++;
            $display("FAIL reset_idle rgbi=%h exp=%h", rgbi, 4'h2);
        end
        for (int i = 0; i < 4; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== 4'h2) begin
                errors++;
                $display("FAIL idle_border px%0d rgbi=%h exp=%h", i, rgbi, 4'h2);
            end
        end
    endtask

    task automatic test_plain_text();
        logic [3:0] exp8 [8];
        set_defaults();
        do_reset();
        charbuf[0]    = 8'hA5;
        attrbuf[0][0] = 8'h07;
        attrbuf[1][0] = 8'h05;
        col  = 8'd1;
        exp8 = '{4'h7, 4'h0, 4'h7, 4'h0, 4'h0, 4'h7, 4'h0, 4'h7};
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== exp8[i]) begin
                errors++;
                $display("FAIL plain px%0d rgbi=%h exp=%h", i, rgbi, exp8[i]);
            end
        end
        // Second attribute row buffer
        rowbuf = 1'b1;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h5) begin
            errors++;
            $display("FAIL rowbuf1 rgbi=%h exp=%h", rgbi, 4'h5);
        end
    endtask

    task automatic test_narrow_semi();
        logic [3:0] exp8 [8];
        set_defaults();
        reg_cdh       = 4'd3;
        charbuf[0]    = 8'hF1;
        attrbuf[0][0] = 8'h07;
        exp8 = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== exp8[i]) begin
                errors++;
                $display("FAIL narrow px%0d rgbi=%h exp=%h", i, rgbi, exp8[i]);
            end
        end
        reg_semi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== 4'h7) begin
                errors++;
                $display("FAIL semi px%0d rgbi=%h exp=%h", i, rgbi, 4'h7);
            end
        end
    endtask

    task automatic test_clamp_truncate();
        logic [3:0] exp8 [8];
        set_defaults();
        reg_cth       = 4'd3;
        reg_cdh       = 4'd7;
        charbuf[0]    = 8'hFF;
        charbuf[1]    = 8'h00;
        attrbuf[0][0] = 8'h07;
        attrbuf[0][1] = 8'h07;
        exp8 = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        col = 8'd1;
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== exp8[i]) begin
                errors++;
                $display("FAIL clamp px%0d rgbi=%h exp=%h", i, rgbi, exp8[i]);
            end
        end
        // Cut a cell short after three pixels
        reg_cth = 4'd7;
        pulse(1'b1, 2'b00);
        pulse(1'b0, 2'b00);
        pulse(1'b0, 2'b00);
        col = 8'd2;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("FAIL truncate rgbi=%h exp=%h", rgbi, 4'h0);
        end
    endtask

    task automatic test_double_width();
        logic [3:0] expv;
        set_defaults();
        reg_dbl       = 1'b1;
        charbuf[0]    = 8'h80;
        attrbuf[0][0] = 8'h07;
        for (int i = 0; i < 16; i++) begin
            pulse(i == 0, 2'b00);
            expv = (i < 2) ? 4'h7 : 4'h0;
            checks++;
            if (rgbi !== expv) begin
                errors++;
                $display("FAIL dbl en%0d rgbi=%h exp=%h", i, rgbi, expv);
            end
        end
    endtask

    task automatic test_cursor_blink();
        set_defaults();
        do_reset();
        reg_cp        = 16'h0105;
        reg_cm        = 2'b10;
        reg_cs        = 5'd0;
        reg_ce        = 5'd8;
        line          = 5'd3;
        attrbuf[0][5] = 8'h07;
        attrbuf[0][6] = 8'h07;
        attrbuf[0][2] = 8'h17;
        charbuf[1]    = 8'h00;
        charbuf[2]    = 8'h00;
        for (int i = 0; i < 7; i++)
            pulse(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
        // Eighth strobe coincides with newCol: counter 8 applies to this cell
        col = 8'd6;
        pulse(1'b1, 2'b01);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL cursor_on rgbi=%h exp=%h", rgbi, 4'h7);
        end
        pulse(1'b0, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL cursor_on_px1 rgbi=%h exp=%h", rgbi, 4'h7);
        end
        col = 8'd7;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("FAIL cursor_miss rgbi=%h exp=%h", rgbi, 4'h0);
        end
        for (int i = 0; i < 8; i++)
            pulse(1'b0, 2'b01);
        col = 8'd6;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("FAIL cursor_off rgbi=%h exp=%h", rgbi, 4'h0);
        end
        // Character blink: counter now 16, bit4=1 -> shown
        charbuf[2] = 8'hFF;
        col = 8'd3;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL blink_shown rgbi=%h exp=%h", rgbi, 4'h7);
        end
        for (int i = 0; i < 16; i++)
            pulse(1'b0, 2'b01);
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("FAIL blink_blanked rgbi=%h exp=%h", rgbi, 4'h0);
        end
        // Counter 32: the slow rate uses bit5, which is set
        reg_crb = 1'b1;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL blink_slow rgbi=%h exp=%h", rgbi, 4'h7);
        end
    endtask

    task automatic test_underline_reverse();
        set_defaults();
        charbuf[0]    = 8'h00;
        attrbuf[0][0] = 8'h27;
        reg_ul        = 5'd3;
        line          = 5'd3;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL underline_on rgbi=%h exp=%h", rgbi, 4'h7);
        end
        line = 5'd4;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("FAIL underline_off rgbi=%h exp=%h", rgbi, 4'h0);
        end
        attrbuf[0][0] = 8'h47;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL attr_reverse rgbi=%h exp=%h", rgbi, 4'h7);
        end
    endtask

    task automatic test_border();
        set_defaults();
        reg_hd        = 8'd4;
        reg_bg        = 4'h2;
        reg_fg        = 4'hE;
        charbuf[3]    = 8'hFF;
        attrbuf[0][3] = 8'h07;
        col = 8'd4;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h7) begin
            errors++;
            $display("FAIL last_col rgbi=%h exp=%h", rgbi, 4'h7);
        end
        col = 8'd5;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h2) begin
            errors++;
            $display("FAIL past_hd rgbi=%h exp=%h", rgbi, 4'h2);
        end
        col = 8'd0;
        pulse(1'b1, 2'b00);
        checks++;
        if (rgbi !== 4'h2) begin
            errors++;
            $display("FAIL col0 rgbi=%h exp=%h", rgbi, 4'h2);
        end
        reg_rvs = 1'b1;
        pulse(1'b0, 2'b00);
        checks++;
        if (rgbi !== 4'hE) begin
            errors++;
            $display("FAIL border_rvs rgbi=%h exp=%h", rgbi, 4'hE);
        end
    endtask

    task automatic test_bitmap_attr();
        logic [3:0] exp8 [8];
        set_defaults();
        reg_text      = 1'b1;
        reg_atr       = 1'b1;
        charbuf[0]    = 8'h0F;
        attrbuf[0][0] = 8'h3C;
        exp8 = '{4'hC, 4'hC, 4'hC, 4'hC, 4'h3, 4'h3, 4'h3, 4'h3};
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== exp8[i]) begin
                errors++;
                $display("FAIL bitmap px%0d rgbi=%h exp=%h", i, rgbi, exp8[i]);
            end
        end
        reg_rvs = 1'b1;
        exp8 = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'hC};
        for (int i = 0; i < 8; i++) begin
            pulse(i == 0, 2'b00);
            checks++;
            if (rgbi !== exp8[i]) begin
                errors++;
                $display("FAIL bitmap_rvs px%0d rgbi=%h exp=%h", i, rgbi, exp8[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_defaults();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_plain_text();
        test_narrow_semi();
        test_clamp_truncate();
        test_double_width();
        test_cursor_blink();
        test_underline_reverse();
        test_border();
        test_bitmap_attr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
